// File: rtl/mem_wb.sv
// rtl/mem_wb.sv - MEM/WB pipeline register with hit-gated advance and async clear
module mem_wb #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTL_W  = 2
) (
  input  logic [CTL_W-1:0]  i_ctlwb,
  input  logic [DATA_W-1:0] iread_data_mem,
  input  logic [DATA_W-1:0] ialu_result,
  input  logic [REG_W-1:0]  ireg_write,
  output logic [CTL_W-1:0]  o_ctlwb,
  output logic [DATA_W-1:0] oread_data_mem,
  output logic [DATA_W-1:0] oalu_result,
  output logic [REG_W-1:0]  oreg_write,
  input  logic              clk,
  input  logic              rstn,
  input  logic              hit
);

  // All four fields share one enable so a stall can never split a pipeline slot.
  // A non-1 hit (including X/Z in simulation) falls through and holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_ctlwb        <= '0;
      oread_data_mem <= '0;
      oalu_result    <= '0;
      oreg_write     <= '0;
    end else if (hit) begin
      o_ctlwb        <= i_ctlwb;
      oread_data_mem <= iread_data_mem;
      oalu_result    <= ialu_result;
      oreg_write     <= ireg_write;
    end
  end

endmodule

// File: tb/tb_mem_wb.sv
// tb/tb_mem_wb.sv - scoreboard bench for mem_wb
module tb_mem_wb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hit;
  logic [1:0]  i_ctlwb, o_ctlwb;
  logic [31:0] iread_data_mem, oread_data_mem;
  logic [31:0] ialu_result, oalu_result;
  logic [4:0]  ireg_write, oreg_write;

  typedef struct {
    string       name;
    logic [1:0]  ctl;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  rg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_wb #(.DATA_W(32), .REG_W(5), .CTL_W(2)) dut (
    .i_ctlwb        (i_ctlwb),
    .iread_data_mem (iread_data_mem),
    .ialu_result    (ialu_result),
    .ireg_write     (ireg_write),
    .o_ctlwb        (o_ctlwb),
    .oread_data_mem (oread_data_mem),
    .oalu_result    (oalu_result),
    .oreg_write     (oreg_write),
    .clk            (clk),
    .rstn           (rstn),
    .hit            (hit)
  );

  always #5 clk = ~clk;

  // Monitor: compares the registered outputs whenever an expectation is posted.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      e = exp_q.pop_front();
      checks++;
      if ({o_ctlwb, oread_data_mem, oalu_result, oreg_write} !== {e.ctl, e.rd, e.alu, e.rg}) begin
        errors++;
        $display("FAIL %s: got ctl=%b rd=%h alu=%h reg=%0d, want ctl=%b rd=%h alu=%h reg=%0d",
                 e.name, o_ctlwb, oread_data_mem, oalu_result, oreg_write,
                 e.ctl, e.rd, e.alu, e.rg);
      end
    end
  end

  task automatic drive(input logic [1:0] c, input logic [31:0] r, input logic [31:0] a,
                       input logic [4:0] g);
    i_ctlwb = c; iread_data_mem = r; ialu_result = a; ireg_write = g;
  endtask

  task automatic expect_out(input string n, input logic [1:0] c, input logic [31:0] r,
                            input logic [31:0] a, input logic [4:0] g);
    exp_t e;
    e.name = n; e.ctl = c; e.rd = r; e.alu = a; e.rg = g;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    hit  = 1'b1;
    drive(2'b11, 32'hDEADBEEF, 32'h12345678, 5'd31);
    #1;
    expect_out("reset_at_t0", 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    expect_out("reset_holds_over_edge", 2'b00, 32'h0, 32'h0, 5'd0);

    rstn = 1'b1;
    expect_out("pre_edge_still_zero", 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    expect_out("first_capture", 2'b11, 32'hDEADBEEF, 32'h12345678, 5'd31);

    hit = 1'b0;
    drive(2'b01, 32'h0, 32'hFFFFFFFF, 5'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("stall_hold_%0d", i), 2'b11, 32'hDEADBEEF, 32'h12345678, 5'd31);
    end
    hit = 1'b1;
    tick();
    expect_out("resume_captures_current", 2'b01, 32'h0, 32'hFFFFFFFF, 5'd1);

    for (int i = 1; i <= 3; i++) begin
      drive(2'b01, 32'h0, i, 5'd1);
      tick();
      expect_out($sformatf("back_to_back_%0d", i), 2'b01, 32'h0, i, 5'd1);
    end

    drive(2'b10, 32'hA5A55A5A, 32'h80000001, 5'd16);
    tick();
    expect_out("bit_exact_pattern", 2'b10, 32'hA5A55A5A, 32'h80000001, 5'd16);
    drive(2'b01, 32'h11111111, 32'h22222222, 5'd3);
    expect_out("mid_cycle_input_change", 2'b10, 32'hA5A55A5A, 32'h80000001, 5'd16);

    hit = 1'bx;
    tick();
    expect_out("hit_x_holds", 2'b10, 32'hA5A55A5A, 32'h80000001, 5'd16);
    hit = 1'b1;

    // 3 ns reset pulse between edges while outputs hold nonzero data
    #1;
    rstn = 1'b0;
    #1;
    expect_out("async_reset_immediate", 2'b00, 32'h0, 32'h0, 5'd0);
    #1;
    rstn = 1'b1;
    expect_out("zero_until_next_edge", 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    expect_out("capture_after_reset", 2'b01, 32'h11111111, 32'h22222222, 5'd3);

    hit = 1'b0;
    rstn = 1'b0;
    #1;
    expect_out("reset_beats_stall", 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    expect_out("reset_beats_stall_edge", 2'b00, 32'h0, 32'h0, 5'd0);
    rstn = 1'b1;
    hit = 1'b1;
    drive(2'b11, 32'h0BADF00D, 32'hCAFEBABE, 5'd7);
    tick();
    expect_out("final_capture", 2'b11, 32'h0BADF00D, 32'hCAFEBABE, 5'd7);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 Parameter DATA_W, default 32: width of memory read data and ALU result.
REQ-002 Parameter REG_W, default 5: width of destination register index.
REQ-003 Parameter CTL_W, default 2: width of write-back control bundle.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 hit  input  1  memory/cache hit; 1 = advance pipeline, 0 = stall (hold).
REQ-007 i_ctlwb  input  CTL_W  write-back control from MEM stage (bit0 RegWrite, bit1 MemtoReg).
REQ-008 iread_data_mem  input  DATA_W  data read from data memory.
REQ-009 ialu_result  input  DATA_W  ALU result forwarded from MEM stage.
REQ-010 ireg_write  input  REG_W  destination register index.
REQ-011 o_ctlwb  output  CTL_W  registered i_ctlwb.
REQ-012 oread_data_mem  output  DATA_W  registered iread_data_mem.
REQ-013 oalu_result  output  DATA_W  registered ialu_result.
REQ-014 oreg_write  output  REG_W  registered ireg_write.
REQ-015 Positional port order SHALL be: i_ctlwb, iread_data_mem, ialu_result, ireg_write, o_ctlwb, oread_data_mem, oalu_result, oreg_write, clk, rstn, hit.

Function
REQ-016 All outputs SHALL be driven directly from flip-flops; no combinational input-to-output path.
REQ-017 On a rising clk edge with rstn=1 and hit=1, every output SHALL take the value its corresponding input had before the edge (latency exactly one cycle).
REQ-018 On a rising clk edge with rstn=1 and hit=0, every output SHALL hold its previous value (stall); all four fields stall together, never partially.
REQ-019 Inputs changing between clock edges SHALL have no effect on outputs.
REQ-020 hit=X/Z SHALL be treated as a stall (outputs hold) in simulation.
REQ-021 Widths SHALL be passed through bit-exact; no sign extension, truncation or arithmetic.
REQ-022 After a stall, the first edge with hit=1 SHALL capture the inputs present at that edge, not those present when the stall began.

Reset
REQ-023 rstn=0 SHALL immediately, independent of clk, force o_ctlwb=0, oread_data_mem=0, oalu_result=0, oreg_write=0.
REQ-024 While rstn=0, outputs SHALL remain 0 regardless of clk, hit or inputs.
REQ-025 Reset asserted mid-operation (including during a stall) SHALL clear all outputs asynchronously and discard held data.
REQ-026 On the first rising edge after rstn deasserts, normal capture per REQ-017/018 SHALL apply; reset deassertion coincident with an edge SHALL not corrupt state (outputs either 0 or the captured inputs, all fields consistent).
REQ-027 The write-back control bundle reset to 0 SHALL guarantee no register write is requested after reset.

Verification
REQ-028 rstn=0 at t=0 with inputs i_ctlwb=2'b11, iread_data_mem=32'hDEADBEEF, ialu_result=32'h12345678, ireg_write=5'd31, no clock edge -> all outputs 0.
REQ-029 rstn=1, hit=1, inputs as REQ-028, one rising edge -> o_ctlwb=2'b11, oread_data_mem=32'hDEADBEEF, oalu_result=32'h12345678, oreg_write=31; before the edge, outputs still 0.
REQ-030 hit=0, inputs changed to 2'b01/32'h0/32'hFFFFFFFF/5'd1, three edges -> outputs remain REQ-029 values; then hit=1, one edge -> outputs 2'b01/32'h0/32'hFFFFFFFF/1.
REQ-031 Back-to-back: hit=1, inputs ialu_result=1,2,3 on consecutive edges -> oalu_result=1,2,3 each one cycle after the corresponding input.
REQ-032 rstn pulsed low for 3 ns between edges while outputs hold nonzero data -> outputs 0 immediately at rstn fall, stay 0 until next edge after rstn=1, then capture inputs.
REQ-033 Simultaneous hit=0 and rstn=0 -> reset wins, outputs 0.
